// File: rtl/reset_sequencer.sv
// Staged reset release for the config, core and FIFO domains, with a completion
// timestamp-sync pulse, soft-reset handling and standalone timestamp-sync requests.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_n_sync,
  input  logic reset_n_config_sync,
  input  logic soft_reset_req,
  input  logic ts_sync_req,
  output logic rst_n_config,
  output logic rst_n_core,
  output logic rst_n_fifo,
  output logic ts_sync,
  output logic busy
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    GAP1 = 2'd1,
    GAP2 = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cfg_pending, cfg_pending_nxt;
  logic          rst_n_config_nxt, rst_n_core_nxt, rst_n_fifo_nxt;
  logic          ts_sync_nxt;

  logic hard_req, cfg_req;
  assign hard_req = ~reset_n_sync;
  assign cfg_req  = ~reset_n_config_sync;

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HOLD;
      cnt          <= '0;
      cfg_pending  <= 1'b1;
      rst_n_config <= 1'b0;
      rst_n_core   <= 1'b0;
      rst_n_fifo   <= 1'b0;
      ts_sync      <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cfg_pending  <= cfg_pending_nxt;
      rst_n_config <= rst_n_config_nxt;
      rst_n_core   <= rst_n_core_nxt;
      rst_n_fifo   <= rst_n_fifo_nxt;
      ts_sync      <= ts_sync_nxt;
      busy         <= (state_nxt != RUN);
    end
  end

  // Next state and next output values; requests take priority cfg > hard > soft > ts
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    cfg_pending_nxt  = cfg_pending;
    rst_n_config_nxt = rst_n_config;
    rst_n_core_nxt   = rst_n_core;
    rst_n_fifo_nxt   = rst_n_fifo;
    ts_sync_nxt      = 1'b0;

    if (cfg_req) begin
      state_nxt        = HOLD;
      cnt_nxt          = '0;
      cfg_pending_nxt  = 1'b1;
      rst_n_config_nxt = 1'b0;
      rst_n_core_nxt   = 1'b0;
      rst_n_fifo_nxt   = 1'b0;
    end else if (hard_req) begin
      // Config domain only re-enters reset if a config release is still owed
      state_nxt      = HOLD;
      cnt_nxt        = '0;
      rst_n_core_nxt = 1'b0;
      rst_n_fifo_nxt = 1'b0;
      if (state == HOLD && cfg_pending) rst_n_config_nxt = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          rst_n_core_nxt = 1'b0;
          rst_n_fifo_nxt = 1'b0;
          if (cfg_pending) rst_n_config_nxt = 1'b0;
          if (cnt == HOLD_LAST) begin
            rst_n_config_nxt = 1'b1;
            cfg_pending_nxt  = 1'b0;
            cnt_nxt          = '0;
            state_nxt        = GAP1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GAP1: begin
          if (cnt == GAP_LAST) begin
            rst_n_core_nxt = 1'b1;
            cnt_nxt        = '0;
            state_nxt      = GAP2;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GAP2: begin
          if (cnt == GAP_LAST) begin
            rst_n_fifo_nxt = 1'b1;
            ts_sync_nxt    = 1'b1;
            cnt_nxt        = '0;
            state_nxt      = RUN;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN: begin
          if (soft_reset_req) begin
            state_nxt      = HOLD;
            cnt_nxt        = '0;
            rst_n_core_nxt = 1'b0;
            rst_n_fifo_nxt = 1'b0;
          end else if (ts_sync_req) begin
            ts_sync_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters (HOLD 16, GAP 4).
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset_n_sync = 1'b1;
  logic reset_n_config_sync = 1'b1;
  logic soft_reset_req = 1'b0;
  logic ts_sync_req = 1'b0;
  logic rst_n_config, rst_n_core, rst_n_fifo, ts_sync, busy;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.HOLD_CYCLES(16), .STAGE_GAP(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .reset_n_sync        (reset_n_sync),
    .reset_n_config_sync (reset_n_config_sync),
    .soft_reset_req      (soft_reset_req),
    .ts_sync_req         (ts_sync_req),
    .rst_n_config        (rst_n_config),
    .rst_n_core          (rst_n_core),
    .rst_n_fifo          (rst_n_fifo),
    .ts_sync             (ts_sync),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic cfg, input logic core,
                     input logic fifo, input logic ts, input logic bsy);
    check({tag, ".cfg"},  rst_n_config, cfg);
    check({tag, ".core"}, rst_n_core,   core);
    check({tag, ".fifo"}, rst_n_fifo,   fifo);
    check({tag, ".ts"},   ts_sync,      ts);
    check({tag, ".busy"}, busy,         bsy);
  endtask

  initial begin
    // Async reset before any clock edge
    #1 reset = 1'b1;
    #1 chk("por_async", 0, 0, 0, 0, 1);
    step(2);
    reset = 1'b0;

    // Power-up release: 16 / 20 / 24
    step(15); chk("pu_e15", 0, 0, 0, 0, 1);
    step(1);  chk("pu_e16", 1, 0, 0, 0, 1);
    step(3);  chk("pu_e19", 1, 0, 0, 0, 1);
    step(1);  chk("pu_e20", 1, 1, 0, 0, 1);
    step(3);  chk("pu_e23", 1, 1, 0, 0, 1);
    step(1);  chk("pu_e24", 1, 1, 1, 1, 0);
    step(1);  chk("pu_e25", 1, 1, 1, 0, 0);

    // Hard request in RUN for 5 cycles; config stays released
    reset_n_sync = 1'b0;
    step(1);  chk("hard_assert", 1, 0, 0, 0, 1);
    step(4);
    reset_n_sync = 1'b1;
    step(15); chk("hard_e15", 1, 0, 0, 0, 1);
    step(1);  chk("hard_e16", 1, 0, 0, 0, 1);
    step(3);  chk("hard_e19", 1, 0, 0, 0, 1);
    step(1);  chk("hard_e20", 1, 1, 0, 0, 1);
    step(3);  chk("hard_e23", 1, 1, 0, 0, 1);
    step(1);  chk("hard_e24", 1, 1, 1, 1, 0);
    step(1);  chk("hard_e25", 1, 1, 1, 0, 0);

    // Soft reset in RUN: core and FIFO only
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    chk("soft_run", 1, 0, 0, 0, 1);
    step(16); chk("soft_e16", 1, 0, 0, 0, 1);
    // In GAP1: soft and ts requests are ignored
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    chk("soft_gap1", 1, 0, 0, 0, 1);
    ts_sync_req = 1'b1;
    step(1);
    ts_sync_req = 1'b0;
    chk("ts_busy", 1, 0, 0, 0, 1);
    step(2);  chk("soft_e20", 1, 1, 0, 0, 1);

    // Config request during GAP2: full sequence repeats
    reset_n_config_sync = 1'b0;
    step(1);
    reset_n_config_sync = 1'b1;
    chk("cfg_gap2", 0, 0, 0, 0, 1);
    step(15); chk("cfg_e15", 0, 0, 0, 0, 1);
    step(1);  chk("cfg_e16", 1, 0, 0, 0, 1);
    step(3);  chk("cfg_e19", 1, 0, 0, 0, 1);
    step(1);  chk("cfg_e20", 1, 1, 0, 0, 1);
    step(3);  chk("cfg_e23", 1, 1, 0, 0, 1);
    step(1);  chk("cfg_e24", 1, 1, 1, 1, 0);
    step(1);  chk("cfg_e25", 1, 1, 1, 0, 0);

    // Timestamp sync request in RUN
    ts_sync_req = 1'b1;
    step(1);
    ts_sync_req = 1'b0;
    chk("ts_run", 1, 1, 1, 1, 0);
    step(1);  chk("ts_run_end", 1, 1, 1, 0, 0);

    // Single-cycle glitch during HOLD restarts the count
    reset_n_sync = 1'b0;
    step(1);
    reset_n_sync = 1'b1;
    chk("glitch_enter", 1, 0, 0, 0, 1);
    step(10);
    reset_n_sync = 1'b0;
    step(1);
    reset_n_sync = 1'b1;
    step(19); chk("glitch_e19", 1, 0, 0, 0, 1);
    step(1);  chk("glitch_e20", 1, 1, 0, 0, 1);
    step(4);  chk("glitch_e24", 1, 1, 1, 1, 0);

    // Async reset mid-GAP1, then cfg_pending forces a config release cycle
    reset_n_sync = 1'b0;
    step(1);
    reset_n_sync = 1'b1;
    step(18); chk("pre_async", 1, 0, 0, 0, 1);
    #2 reset = 1'b1;
    #1 chk("async_mid", 0, 0, 0, 0, 1);
    step(1);
    reset = 1'b0;
    step(15); chk("rel_e15", 0, 0, 0, 0, 1);
    step(1);  chk("rel_e16", 1, 0, 0, 0, 1);
    step(4);  chk("rel_e20", 1, 1, 0, 0, 1);
    step(4);  chk("rel_e24", 1, 1, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
